// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: default widths, memory-op encoding and
// the EX->MEM payload layout.
package cpu_pkg;

  localparam int unsigned DEF_XLEN   = 32;
  localparam int unsigned DEF_RA_W   = 5;
  localparam int unsigned DEF_MEME_W = 4;

  localparam logic [DEF_MEME_W-1:0] MEM_NONE = '0;

  typedef struct packed {
    logic [DEF_RA_W-1:0]   wa;
    logic                  we;
    logic [DEF_XLEN-1:0]   wn;
    logic [DEF_MEME_W-1:0] mem_e;
    logic [DEF_XLEN-1:0]   mem_n;
  } ex_mm_payload_t;

  localparam int unsigned EX_MM_PAYLOAD_W = $bits(ex_mm_payload_t);

endpackage

// File: rtl/pipe_skid2.sv
// Generic 2-entry valid/ready skid buffer over an opaque W-bit payload.
// Head entry drives the output; the skid entry absorbs one beat when the
// consumer stalls so in_ready can be a register. flush empties both entries.
module pipe_skid2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         s_valid,
  output logic [W-1:0] s_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  skid_state_t r_state;
  skid_state_t w_state_next;
  logic [W-1:0] r_h;
  logic [W-1:0] r_s;
  logic         r_in_ready;
  logic         w_tin;
  logic         w_tout;
  logic         w_ld_h_in;
  logic         w_ld_h_s;
  logic         w_ld_s;

  assign w_tin     = in_valid & r_in_ready;
  assign w_tout    = out_valid & out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_h;
  assign s_valid   = (r_state == ST_TWO);
  assign s_data    = r_s;

  // Next-state and payload load selects; flush overrides every transfer.
  always_comb begin
    w_state_next = r_state;
    w_ld_h_in    = 1'b0;
    w_ld_h_s     = 1'b0;
    w_ld_s       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_tin) begin
          w_ld_h_in    = 1'b1;
          w_state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_tin && w_tout) begin
          w_ld_h_in = 1'b1;
        end else if (w_tin) begin
          w_ld_s       = 1'b1;
          w_state_next = ST_TWO;
        end else if (w_tout) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_tout) begin
          w_ld_h_s     = 1'b1;
          w_state_next = ST_ONE;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_next = ST_EMPTY;
      w_ld_h_in    = 1'b0;
      w_ld_h_s     = 1'b0;
      w_ld_s       = 1'b0;
    end
  end

  // State register; in_ready registers whether the skid entry will be free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_TWO);
    end
  end

  // Payload storage; contents left stale on flush, validity lives in r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h <= '0;
      r_s <= '0;
    end else begin
      if (w_ld_h_in) r_h <= in_data;
      else if (w_ld_h_s) r_h <= r_s;
      if (w_ld_s) r_s <= in_data;
    end
  end

endmodule

// File: rtl/ex_mm_pipe.sv
// EX->MEM pipeline stage: 2-entry skid buffer with x0-write suppression and
// memory-op masking on the head entry. Optional forwarding tap for the
// hazard unit is enabled by defining EX_MM_FWD_EN.
// The payload layout is cpu_pkg::ex_mm_payload_t, so width overrides must
// match the package defaults.
module ex_mm_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN   = DEF_XLEN,
  parameter int unsigned RA_W   = DEF_RA_W,
  parameter int unsigned MEME_W = DEF_MEME_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RA_W-1:0]   ex_wa,
  input  logic              ex_we,
  input  logic [XLEN-1:0]   ex_wn,
  input  logic [MEME_W-1:0] ex_mem_e,
  input  logic [XLEN-1:0]   ex_mem_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RA_W-1:0]   mm_wa,
  output logic              mm_we,
  output logic [XLEN-1:0]   mm_wn,
  output logic [MEME_W-1:0] mm_mem_e,
  output logic [XLEN-1:0]   mm_mem_n,
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_wa,
  output logic [XLEN-1:0]   fwd_wn
);

  ex_mm_payload_t w_in_pl;
  ex_mm_payload_t w_h;
  ex_mm_payload_t w_s;
  logic           w_out_valid;
  logic           w_s_valid;

  // Entry payload; write enable qualified against x0 before storage.
  always_comb begin
    w_in_pl       = '0;
    w_in_pl.wa    = ex_wa;
    w_in_pl.we    = ex_we & (ex_wa != '0);
    w_in_pl.wn    = ex_wn;
    w_in_pl.mem_e = ex_mem_e;
    w_in_pl.mem_n = ex_mem_n;
  end

  pipe_skid2 #(
    .W(EX_MM_PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (w_in_pl),
    .out_valid(w_out_valid),
    .out_ready(out_ready),
    .out_data (w_h),
    .s_valid  (w_s_valid),
    .s_data   (w_s)
  );

  // Head outputs; we and mem_e masked when the head is not valid.
  always_comb begin
    out_valid = w_out_valid;
    mm_wa     = w_h.wa;
    mm_we     = w_h.we & w_out_valid & (w_h.wa != '0);
    mm_wn     = w_h.wn;
    mm_mem_e  = w_out_valid ? w_h.mem_e : MEM_NONE;
    mm_mem_n  = w_h.mem_n;
  end

`ifdef EX_MM_FWD_EN
  logic w_s_fwd;
  logic w_h_fwd;

  assign w_s_fwd = w_s_valid & w_s.we & (w_s.wa != '0);
  assign w_h_fwd = w_out_valid & w_h.we & (w_h.wa != '0);

  // Forward the youngest valid writing entry (skid before head).
  always_comb begin
    fwd_valid = 1'b0;
    fwd_wa    = '0;
    fwd_wn    = '0;
    if (w_s_fwd) begin
      fwd_valid = 1'b1;
      fwd_wa    = w_s.wa;
      fwd_wn    = w_s.wn;
    end else if (w_h_fwd) begin
      fwd_valid = 1'b1;
      fwd_wa    = w_h.wa;
      fwd_wn    = w_h.wn;
    end
  end
`else
  logic w_unused_fwd;

  assign w_unused_fwd = ^{w_s_valid, w_s};

  // Forwarding tap disabled: outputs tied off.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_wa    = '0;
    fwd_wn    = '0;
  end
`endif

endmodule
